// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer and empty-flag controller for the asynchronous FIFO.
// Synchronises the write Gray pointer into the read domain, advances the
// binary/Gray read pointers on accepted increments and registers the empty,
// fill-level and sticky underflow flags.
module fifo_rd_ptr_ctrl #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_incr,
  input  logic                i_clr_err,
  input  logic [ADDR_W:0]     i_wr_ptr_gray,
  output logic [ADDR_W-1:0]   o_rd_addr,
  output logic [ADDR_W:0]     o_rd_ptr_gray,
  output logic                o_empty,
  output logic [ADDR_W:0]     o_level,
  output logic                o_underflow
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] wr_gray_m;
  logic [PTR_W-1:0] wr_gray_s;
  logic [PTR_W-1:0] wr_bin_s;
  logic [PTR_W-1:0] rd_bin;
  logic [PTR_W-1:0] rd_bin_nxt;
  logic [PTR_W-1:0] rd_gray_nxt;
  logic             acc;
  logic             underflow_set;

  // Two-flop synchroniser for the write-domain Gray pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_gray_m <= '0;
      wr_gray_s <= '0;
    end else begin
      wr_gray_m <= i_wr_ptr_gray;
      wr_gray_s <= wr_gray_m;
    end
  end

  // Gray-to-binary conversion of the synchronised write pointer
  always_comb begin
    wr_bin_s = '0;
    wr_bin_s[PTR_W-1] = wr_gray_s[PTR_W-1];
    for (int i = int'(PTR_W) - 2; i >= 0; i--) begin
      wr_bin_s[i] = wr_bin_s[i+1] ^ wr_gray_s[i];
    end
  end

  // Next read pointer: only advance when the FIFO holds data
  always_comb begin
    acc           = i_incr & ~o_empty;
    underflow_set = i_incr & o_empty;
    rd_bin_nxt    = rd_bin + PTR_W'(acc);
    rd_gray_nxt   = rd_bin_nxt ^ (rd_bin_nxt >> 1);
  end

  // Pointer and flag registers; flags use the post-increment pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bin        <= '0;
      o_rd_ptr_gray <= '0;
      o_empty       <= 1'b1;
      o_level       <= '0;
    end else begin
      rd_bin        <= rd_bin_nxt;
      o_rd_ptr_gray <= rd_gray_nxt;
      o_empty       <= (rd_gray_nxt == wr_gray_s);
      o_level       <= wr_bin_s - rd_bin_nxt;
    end
  end

  // Sticky underflow; a new underflow beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_underflow <= 1'b0;
    end else if (underflow_set) begin
      o_underflow <= 1'b1;
    end else if (i_clr_err) begin
      o_underflow <= 1'b0;
    end
  end

  assign o_rd_addr = rd_bin[ADDR_W-1:0];

endmodule
